// File: rtl/nmi_pkg.sv
// nmi_pkg: shared FSM states, out-of-range fill word and strobe-to-write decode for nmi_slave_mem.
package nmi_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;
  localparam int MAX_STRB = 128;
  function automatic logic is_write(input logic [MAX_STRB-1:0] strb);
    return |strb;
  endfunction
endpackage

// File: rtl/nmi_bytemem.sv
// nmi_bytemem: byte-enabled word storage, one write port and one asynchronous read port, not reset.
module nmi_bytemem #(
  parameter int DATA_WIDTH  = 32,
  parameter int WSTRB_WIDTH = 4,
  parameter int DEPTH       = 256,
  localparam int IW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [WSTRB_WIDTH-1:0] wstrb,
  input  logic [IW-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic [IW-1:0]          raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mask;
  always_comb
    for (int j = 0; j < DATA_WIDTH; j++) mask[j] = wstrb[j/8];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= (mem[waddr] & ~mask) | (wdata & mask);
  assign rdata = mem[raddr];
endmodule

// File: rtl/nmi_slave_mem.sv
// nmi_slave_mem: NMI slave memory with programmable wait states.
// Define NMI_SLAVE_ERRCNT_EN to add a saturating out-of-range access counter (err_count).
module nmi_slave_mem
  import nmi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WSTRB_WIDTH = (DATA_WIDTH-1)/8+1,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_nmi_valid,
  output logic                   s_nmi_ready,
  input  logic                   s_nmi_instr,
  input  logic [ADDR_WIDTH-1:0]  s_nmi_addr,
  input  logic [DATA_WIDTH-1:0]  s_nmi_wdata,
  input  logic [WSTRB_WIDTH-1:0] s_nmi_wstrb,
  output logic [DATA_WIDTH-1:0]  s_nmi_rdata
`ifdef NMI_SLAVE_ERRCNT_EN
  ,output logic [15:0]           err_count
`endif
);
  localparam int IW  = $clog2(DEPTH);
  localparam int REP = (DATA_WIDTH+31)/32;
  localparam logic [REP*32-1:0] FILL = {REP{DEADBEEF}};
  state_t state, next;
  logic [3:0] cnt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata, mem_rdata;
  logic [WSTRB_WIDTH-1:0] req_wstrb;
  logic oor, fire, we;
  logic unused_instr;
  assign unused_instr = s_nmi_instr;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
    end else begin
      state <= next;
      if (state == IDLE && s_nmi_valid) begin
        cnt       <= 4'(WAIT_CYCLES);
        req_addr  <= s_nmi_addr;
        req_wdata <= s_nmi_wdata;
        req_wstrb <= s_nmi_wstrb;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
    end
  // Dropping valid anywhere in WAIT abandons the request before it can reach RESP.
  always_comb
    next = state == IDLE ? (s_nmi_valid ? (WAIT_CYCLES != 0 ? WAIT : RESP) : IDLE)
         : state == WAIT ? (!s_nmi_valid ? IDLE : cnt == 4'd1 ? RESP : WAIT)
         : IDLE;
  always_comb begin
    s_nmi_ready = state == RESP;
    fire        = s_nmi_ready && s_nmi_valid;
    oor         = |(req_addr >> (IW+2));
    we          = fire && !oor && is_write(MAX_STRB'(req_wstrb));
    s_nmi_rdata = !s_nmi_ready ? '0 : oor ? FILL[DATA_WIDTH-1:0] : mem_rdata;
  end
  nmi_bytemem #(.DATA_WIDTH(DATA_WIDTH), .WSTRB_WIDTH(WSTRB_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .wstrb (req_wstrb),
    .waddr (req_addr[IW+1:2]),
    .wdata (req_wdata),
    .raddr (req_addr[IW+1:2]),
    .rdata (mem_rdata)
  );
`ifdef NMI_SLAVE_ERRCNT_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) err_count <= '0;
    else if (fire && oor && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule

// File: tb/tb_nmi_slave_mem.sv
// tb_nmi_slave_mem: self-checking bench driving a WAIT_CYCLES=0 and a WAIT_CYCLES=3 instance.
module tb_nmi_slave_mem;
  logic clk = 1'b0, rstn = 1'b0;
  logic [1:0] valid = '0, instr = '0, ready;
  logic [1:0][31:0] addr = '0, wdata = '0, rdata;
  logic [1:0][3:0] wstrb = '0;
  int total = 0, bad = 0;
  logic [31:0] mm [2][256];
  bit vb [2][256][4];
  int ec [2] = '{0, 0};
`ifdef NMI_SLAVE_ERRCNT_EN
  logic [1:0][15:0] errc;
`endif
  always #5 clk = ~clk;

  nmi_slave_mem #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .s_nmi_valid(valid[0]), .s_nmi_ready(ready[0]),
    .s_nmi_instr(instr[0]), .s_nmi_addr(addr[0]), .s_nmi_wdata(wdata[0]),
    .s_nmi_wstrb(wstrb[0]), .s_nmi_rdata(rdata[0])
`ifdef NMI_SLAVE_ERRCNT_EN
    , .err_count(errc[0])
`endif
  );
  nmi_slave_mem #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rstn(rstn), .s_nmi_valid(valid[1]), .s_nmi_ready(ready[1]),
    .s_nmi_instr(instr[1]), .s_nmi_addr(addr[1]), .s_nmi_wdata(wdata[1]),
    .s_nmi_wstrb(wstrb[1]), .s_nmi_rdata(rdata[1])
`ifdef NMI_SLAVE_ERRCNT_EN
    , .err_count(errc[1])
`endif
  );

  function automatic int wcyc(input int s);
    return s == 1 ? 3 : 0;
  endfunction

  task automatic txn(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                     input bit keep, input string nm, output logic [31:0] got);
    int n;
    bit oor, known;
    logic [7:0] idx;
    logic [31:0] exp;
    oor = a >= 32'h400;
    idx = a[9:2];
    known = vb[s][idx][0] && vb[s][idx][1] && vb[s][idx][2] && vb[s][idx][3];
    exp = oor ? 32'hDEADBEEF : mm[s][idx];
    addr[s] = a; wdata[s] = d; wstrb[s] = st; instr[s] = 1'($urandom); valid[s] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin addr[s] = $urandom; wdata[s] = $urandom; wstrb[s] = 4'($urandom); end
    end while (!ready[s] && n < 40);
    total++;
    if (ready[s] !== 1'b1 || n != wcyc(s)+1) begin
      bad++; $display("FAIL %s latency: got %0d cycles (ready=%b) want %0d", nm, n, ready[s], wcyc(s)+1);
    end
    got = rdata[s];
    if (oor || known) begin
      total++;
      if (got !== exp) begin bad++; $display("FAIL %s rdata: got %h want %h", nm, got, exp); end
    end
    @(posedge clk); #1;
    if (oor) ec[s]++;
    else for (int b = 0; b < 4; b++)
      if (st[b]) begin mm[s][idx][8*b +: 8] = d[8*b +: 8]; vb[s][idx][b] = 1'b1; end
    total++;
    if (ready[s] !== 1'b0 || rdata[s] !== 32'h0) begin
      bad++; $display("FAIL %s post-ready: ready=%b rdata=%h want 0/0", nm, ready[s], rdata[s]);
    end
`ifdef NMI_SLAVE_ERRCNT_EN
    total++;
    if (errc[s] !== 16'(ec[s])) begin bad++; $display("FAIL %s err_count: got %0d want %0d", nm, errc[s], ec[s]); end
`endif
    if (!keep) valid[s] = 1'b0;
  endtask

  task automatic no_ready(input int s, input string nm);
    bit seen = 0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (ready[s]) seen = 1; end
    total++;
    if (seen) begin bad++; $display("FAIL %s: ready observed=1 want 0", nm); end
  endtask

  task automatic test_reset();
    #1;
    for (int s = 0; s < 2; s++) begin
      total++;
      if (ready[s] !== 1'b0 || rdata[s] !== 32'h0) begin
        bad++; $display("FAIL reset dut%0d: ready=%b rdata=%h want 0/0", s, ready[s], rdata[s]);
      end
`ifdef NMI_SLAVE_ERRCNT_EN
      total++;
      if (errc[s] !== 16'h0) begin bad++; $display("FAIL reset err_count dut%0d: got %0d want 0", s, errc[s]); end
`endif
    end
    valid = '1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] g;
    txn(0, 32'h10, 32'h12345678, 4'hF, 0, "wr_full", g);
    txn(0, 32'h10, 32'h0, 4'h0, 0, "rd_full", g);
    total++;
    if (g !== 32'h12345678) begin bad++; $display("FAIL rd_full literal: got %h want 12345678", g); end
    txn(0, 32'h13, 32'hAAAABBBB, 4'h3, 0, "wr_half", g);
    txn(0, 32'h10, 32'h0, 4'h0, 0, "rd_half", g);
    total++;
    if (g !== 32'h1234BBBB) begin bad++; $display("FAIL rd_half literal: got %h want 1234bbbb", g); end
  endtask

  task automatic test_oor();
    logic [31:0] g;
    txn(0, 32'h0, 32'hCAFEF00D, 4'hF, 0, "oor_seed", g);
    txn(0, 32'h400, 32'h0, 4'h0, 0, "oor_rd", g);
    total++;
    if (g !== 32'hDEADBEEF) begin bad++; $display("FAIL oor_rd literal: got %h want deadbeef", g); end
    txn(0, 32'h400, 32'h11111111, 4'hF, 0, "oor_wr", g);
    txn(0, 32'h8000_0000, 32'h22222222, 4'hF, 0, "oor_wr_hi", g);
    txn(0, 32'h0, 32'h0, 4'h0, 0, "oor_alias", g);
    total++;
    if (g !== 32'hCAFEF00D) begin bad++; $display("FAIL oor_alias literal: got %h want cafef00d", g); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g;
    txn(1, 32'h40, 32'h0BADC0DE, 4'hF, 1, "b2b_wr", g);
    txn(1, 32'h44, 32'h01020304, 4'hF, 1, "b2b_wr2", g);
    txn(1, 32'h40, 32'h0, 4'h0, 1, "b2b_rd", g);
    txn(1, 32'h44, 32'h0, 4'h0, 0, "b2b_rd2", g);
    total++;
    if (g !== 32'h01020304) begin bad++; $display("FAIL b2b_rd2 literal: got %h want 01020304", g); end
  endtask

  task automatic test_abandon();
    logic [31:0] g;
    txn(1, 32'h20, 32'h11223344, 4'hF, 0, "ab_seed", g);
    addr[1] = 32'h20; wdata[1] = 32'h55667788; wstrb[1] = 4'hF; valid[1] = 1'b1;
    @(posedge clk); #1 valid[1] = 1'b0;
    no_ready(1, "abandon_early");
    valid[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 valid[1] = 1'b0;
    no_ready(1, "abandon_late");
    txn(1, 32'h20, 32'h0, 4'h0, 0, "ab_rd", g);
    total++;
    if (g !== 32'h11223344) begin bad++; $display("FAIL ab_rd literal: got %h want 11223344", g); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] g;
    int n;
    txn(1, 32'h24, 32'hA5A5A5A5, 4'hF, 0, "rst_seed", g);
    addr[1] = 32'h24; wdata[1] = 32'h5A5A5A5A; wstrb[1] = 4'hF; valid[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    total++;
    if (ready[1] !== 1'b0 || rdata[1] !== 32'h0) begin
      bad++; $display("FAIL rst_wait: ready=%b rdata=%h want 0/0", ready[1], rdata[1]);
    end
    valid[1] = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    no_ready(1, "rst_wait_after");
    addr[1] = 32'h24; wdata[1] = 32'h5A5A5A5A; wstrb[1] = 4'hF; valid[1] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready[1] && n < 40);
    rstn = 1'b0;
    #1;
    total++;
    if (ready[1] !== 1'b0 || rdata[1] !== 32'h0) begin
      bad++; $display("FAIL rst_resp: ready=%b rdata=%h want 0/0 (waited %0d)", ready[1], rdata[1], n);
    end
    valid[1] = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    txn(1, 32'h24, 32'h0, 4'h0, 0, "rst_rd", g);
    total++;
    if (g !== 32'hA5A5A5A5) begin bad++; $display("FAIL rst_rd literal: got %h want a5a5a5a5", g); end
  endtask

  task automatic test_random();
    logic [31:0] g, a;
    logic [3:0] st;
    for (int i = 0; i < 60; i++) begin
      int s = i % 2;
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = (32'h400 << $urandom_range(0, 21)) | a;
      st = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(1, 15));
      txn(s, a, $urandom, st, $urandom_range(0, 1) == 1, "random", g);
      valid[s] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_oor();
    test_back_to_back();
    test_abandon();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nmi_slave_mem.md
NMI_SLAVE_MEM -- requirements
Module: nmi_slave_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: NMI address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32: NMI data width in bits.
REQ-003 Parameter WSTRB_WIDTH, default (DATA_WIDTH-1)/8+1: byte-strobe width.
REQ-004 Parameter DEPTH, default 256: number of DATA_WIDTH-bit words of storage; a power of two, at least 2.
REQ-005 Parameter WAIT_CYCLES, default 0: extra cycles between request acceptance and s_nmi_ready; range 0..15.
REQ-006 clk  input  1: single clock; all state updates on its rising edge.
REQ-007 rstn  input  1: reset, asynchronous and active-low.
REQ-008 s_nmi_valid  input  1: request valid from the initiator.
REQ-009 s_nmi_ready  output  1: completion strobe; the transaction completes in the cycle where s_nmi_valid and s_nmi_ready are both high.
REQ-010 s_nmi_instr  input  1: instruction-fetch flag; accepted but functionally ignored.
REQ-011 s_nmi_addr  input  ADDR_WIDTH: byte address.
REQ-012 s_nmi_wdata  input  DATA_WIDTH: write data.
REQ-013 s_nmi_wstrb  input  WSTRB_WIDTH: byte enables; nonzero means write, zero means read.
REQ-014 s_nmi_rdata  output  DATA_WIDTH: read data, valid while s_nmi_ready is high.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 In IDLE with s_nmi_valid=1, the block SHALL capture addr, wdata and wstrb into request registers, load the wait counter with WAIT_CYCLES, and go to WAIT if WAIT_CYCLES>0, otherwise to RESP.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 1.
REQ-018 s_nmi_ready SHALL be high only in RESP; RESP SHALL last exactly one cycle and then return to IDLE.
REQ-019 Request latency, from the acceptance cycle to the ready cycle, SHALL be WAIT_CYCLES+1; back-to-back transactions SHALL be accepted every WAIT_CYCLES+2 cycles.
REQ-020 Changes on addr, wdata or wstrb after acceptance SHALL be ignored; the captured values govern the transaction.
REQ-021 Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored.
REQ-022 An address is out of range when any addr bit above log2(DEPTH)+1 is set.
REQ-023 A write SHALL commit in the RESP cycle, per byte lane where wstrb is set; other lanes SHALL be unchanged.
REQ-024 A read SHALL return the word stored before any same-cycle write; out-of-range reads SHALL return 32'hDEAD_BEEF, replicated or truncated to DATA_WIDTH.
REQ-025 Out-of-range writes SHALL be discarded.
REQ-026 If s_nmi_valid falls in WAIT, or falls in the cycle before RESP, the transaction SHALL be abandoned: go to IDLE, no write, no ready.
REQ-027 s_nmi_rdata SHALL be 0 whenever s_nmi_ready is low.

Reset
REQ-028 Asserting rstn low SHALL immediately force IDLE, s_nmi_ready=0, s_nmi_rdata=0, the wait counter to 0 and the request registers to 0.
REQ-029 Storage contents SHALL NOT be reset.
REQ-030 Reset asserted mid-transaction SHALL drop the transaction with no write.
REQ-031 The first acceptance after reset SHALL occur no earlier than the first clock edge with rstn high.

Configuration
REQ-032 Macro NMI_SLAVE_ERRCNT_EN defined: the block SHALL add output err_count (16 bits, reset 0) that increments on each completed out-of-range access and saturates at 16'hFFFF.
REQ-033 Macro NMI_SLAVE_ERRCNT_EN undefined: the err_count port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Package nmi_pkg SHALL hold the FSM state enum, the DEADBEEF fill constant and the strobe-to-write decode function.
REQ-035 Sub-module nmi_bytemem SHALL implement the byte-enabled storage array, with one write port and one asynchronous read port.

Verification
REQ-036 WAIT_CYCLES=0: write addr 0x10, wdata 0x12345678, wstrb 0xF, then read 0x10 -> ready one cycle after each acceptance, rdata 0x12345678.
REQ-037 Write 0x10 with wstrb 0x3 and data 0xAAAABBBB over stored 0x12345678, then read -> 0x1234BBBB.
REQ-038 WAIT_CYCLES=3: valid held high -> ready exactly 4 cycles after acceptance, for one cycle; next acceptance the following cycle.
REQ-039 Read addr 0x400 with DEPTH=256 -> rdata 0xDEADBEEF; with NMI_SLAVE_ERRCNT_EN, err_count goes from 0 to 1.
REQ-040 WAIT_CYCLES=3 write with valid dropped after 1 cycle -> no ready, and a later read returns the old data.
REQ-041 rstn pulsed low during WAIT -> ready stays 0, the FSM is in IDLE, and no write occurs.
